// File: rtl/sock_dti_fifo_pkg.sv
// Shared types and defaults for the socket-to-DTI bridge FIFO.
// The default sizes must match the ones the DPI poll loop is built with.
package sock_dti_pkg;

  localparam int unsigned DEF_W_DATA = 16;
  localparam int unsigned DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

  // The occupancy counter needs one extra bit so that it can hold the value DEPTH.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sock_dti_fifo_mem.sv
// Register array for sock_dti_fifo: one synchronous write port and an asynchronous read port.
// Contents are not reset; the occupancy logic in the top decides which entries are valid.
module sock_dti_fifo_mem
  import sock_dti_pkg::*;
#(
  parameter int unsigned W_DATA = DEF_W_DATA,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W_DATA-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W_DATA-1:0]        rdata
);

  logic [W_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sock_dti_fifo.sv
// Buffers words pushed by the socket poll loop and presents them as a DTI stream;
// tracks end-of-channel. Optional stall counter: define SOCK_DTI_FIFO_STALL_CNT_EN.
module sock_dti_fifo
  import sock_dti_pkg::*;
#(
  parameter int unsigned W_DATA = DEF_W_DATA,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned W_CNT  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      src_valid,
  input  logic [W_DATA-1:0]         src_data,
  output logic                      src_ready,
  input  logic                      src_done,
  output logic                      dout_valid,
  output logic [W_DATA-1:0]         dout_data,
  input  logic                      dout_ready,
  output logic                      done,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic [W_CNT-1:0]          txn_cnt
`ifdef SOCK_DTI_FIFO_STALL_CNT_EN
  ,
  output logic [W_CNT-1:0]          stall_cnt
`endif
);

  localparam int unsigned LW = lvl_w(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   level_q;
  logic [W_CNT-1:0] txn_q;
  logic            push;
  logic            pop;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DRAIN leaves on the cycle after occupancy is seen at zero
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (src_done) state_d = DRAIN;
      DRAIN:   if (level_q == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  // Outputs depend on registered state only, never on dout_ready
  always_comb begin
    src_ready  = (state_q == RUN) && (level_q != LW'(DEPTH));
    done       = (state_q == DONE);
    dout_valid = (level_q != '0);
  end

  assign push = src_valid && src_ready;
  assign pop  = dout_valid && dout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      txn_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        txn_q  <= txn_q + W_CNT'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign level   = level_q;
  assign txn_cnt = txn_q;

`ifdef SOCK_DTI_FIFO_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (dout_valid && !dout_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + W_CNT'(1);
    end
  end
`endif

  sock_dti_fifo_mem #(
    .W_DATA (W_DATA),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (src_data),
    .raddr (rd_ptr),
    .rdata (dout_data)
  );

endmodule

// File: tb/tb_sock_dti_fifo.sv
// Directed self-checking bench for sock_dti_fifo (DEPTH=4, W_DATA=16, W_CNT=32).
// Stall counter checks are compiled in with SOCK_DTI_FIFO_STALL_CNT_EN.
module tb_sock_dti_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        src_valid;
  logic [15:0] src_data;
  logic        src_ready;
  logic        src_done;
  logic        dout_valid;
  logic [15:0] dout_data;
  logic        dout_ready;
  logic        done;
  logic [2:0]  level;
  logic [31:0] txn_cnt;
`ifdef SOCK_DTI_FIFO_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sock_dti_fifo #(
    .W_DATA (16),
    .DEPTH  (4),
    .W_CNT  (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .src_done   (src_done),
    .dout_valid (dout_valid),
    .dout_data  (dout_data),
    .dout_ready (dout_ready),
    .done       (done),
    .level      (level),
    .txn_cnt    (txn_cnt)
`ifdef SOCK_DTI_FIFO_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] w[5];
    int sent;
    logic sv, rdy, mpush, mpop;

    rst = 1'b1; src_valid = 1'b0; src_data = '0; src_done = 1'b0; dout_ready = 1'b0;
    tick(); tick();
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_src_ready", src_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_level", level, 0);
    chk("rst_txn", txn_cnt, 0);
    rst = 1'b0;
    tick();

    // Basic streaming with dout_ready held high
    dout_ready = 1'b1;
    src_valid = 1'b1; src_data = 16'h1111;
    tick();
    chk("basic_v0", dout_valid, 1);
    chk("basic_d0", dout_data, 16'h1111);
    src_data = 16'h2222;
    tick();
    chk("basic_d1", dout_data, 16'h2222);
    chk("basic_lvl1", level, 1);
    src_data = 16'h3333;
    tick();
    chk("basic_d2", dout_data, 16'h3333);
    src_valid = 1'b0;
    tick();
    chk("basic_empty", dout_valid, 0);
    chk("basic_txn", txn_cnt, 3);

    // Full: five pushes against a stalled sink
    dout_ready = 1'b0;
    w[0] = 16'h0A01; w[1] = 16'h0A02; w[2] = 16'h0A03; w[3] = 16'h0A04; w[4] = 16'h0A05;
    src_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_data = w[i];
      tick();
    end
    chk("full_level", level, 4);
    chk("full_src_ready", src_ready, 0);
    src_data = w[4];
    tick();
    chk("full_held_level", level, 4);
    chk("full_head", dout_data, 16'h0A01);
    dout_ready = 1'b1;
    tick();
    chk("full_pop_level", level, 3);
    chk("full_pop_d", dout_data, 16'h0A02);
    chk("full_ready_back", src_ready, 1);
    tick();
    src_valid = 1'b0;
    chk("full_pp_level", level, 3);
    chk("full_d3", dout_data, 16'h0A03);
    tick();
    chk("full_d4", dout_data, 16'h0A04);
    tick();
    chk("full_d5", dout_data, 16'h0A05);
    tick();
    chk("full_empty", dout_valid, 0);
    chk("full_txn", txn_cnt, 8);

    // Wrap: interleaved push/pop stalls against a queue model
    sent = 0;
    for (int cyc = 0; cyc < 60 && (sent < 10 || q.size() > 0); cyc++) begin
      sv  = (sent < 10) && (cyc % 4 != 3);
      rdy = (cyc % 3 != 0);
      src_valid = sv; src_data = 16'hB000 + 16'(sent); dout_ready = rdy;
      mpush = sv && (q.size() < 4);
      mpop  = rdy && (q.size() > 0);
      tick();
      if (mpop) void'(q.pop_front());
      if (mpush) begin
        q.push_back(src_data);
        sent++;
      end
      chk("wrap_valid", dout_valid, (q.size() != 0));
      chk("wrap_level", level, q.size());
      if (q.size() != 0) chk("wrap_data", dout_data, q[0]);
    end
    src_valid = 1'b0;
    chk("wrap_complete", (sent == 10) && (q.size() == 0), 1);
    chk("wrap_txn", txn_cnt, 18);

    // Drain with a push coinciding with src_done
    dout_ready = 1'b0;
    src_valid = 1'b1; src_data = 16'hC001;
    tick();
    src_data = 16'hC002;
    tick();
    chk("drain_level2", level, 2);
    src_data = 16'hAAAA; src_done = 1'b1;
    tick();
    chk("drain_level3", level, 3);
    chk("drain_src_ready", src_ready, 0);
    chk("drain_head", dout_data, 16'hC001);
    src_done = 1'b0; src_data = 16'hBBBB; dout_ready = 1'b1;
    tick();
    chk("drain_d1", dout_data, 16'hC002);
    tick();
    chk("drain_d2", dout_data, 16'hAAAA);
    chk("drain_lvl1", level, 1);
    tick();
    chk("drain_empty", dout_valid, 0);
    chk("drain_not_done_yet", done, 0);
    tick();
    chk("drain_done", done, 1);
    chk("drain_level0", level, 0);
    chk("drain_txn", txn_cnt, 21);
    chk("drain_src_ready_done", src_ready, 0);
    src_valid = 1'b0;

    // Reset returns to RUN, then an asynchronous reset mid-stream
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rerun_done", done, 0);
    chk("rerun_src_ready", src_ready, 1);
    dout_ready = 1'b0;
    src_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_data = 16'hD001 + 16'(i);
      tick();
    end
    src_valid = 1'b0;
    chk("mid_level3", level, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", dout_valid, 0);
    chk("async_level", level, 0);
    chk("async_txn", txn_cnt, 0);
    chk("async_done", done, 0);
    tick();
    rst = 1'b0;
    src_valid = 1'b1; src_data = 16'h5A5A;
    tick();
    src_valid = 1'b0;
    chk("fresh_valid", dout_valid, 1);
    chk("fresh_data", dout_data, 16'h5A5A);
    chk("fresh_level", level, 1);
    repeat (7) tick();
    chk("stall_data_stable", dout_data, 16'h5A5A);
`ifdef SOCK_DTI_FIFO_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 7);
`endif
    dout_ready = 1'b1;
    tick();
    chk("fresh_txn", txn_cnt, 1);
    chk("fresh_empty", dout_valid, 0);
    tick();
    chk("empty_ready_level", level, 0);
    chk("empty_ready_txn", txn_cnt, 1);

    // src_done while empty
    src_done = 1'b1;
    tick();
    src_done = 1'b0;
    chk("empty_drain_done", done, 0);
    chk("empty_drain_ready", src_ready, 0);
    tick();
    chk("empty_done", done, 1);
    chk("empty_done_txn", txn_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
